// File: rtl/lsu_mem_access.sv
// Load/store access unit between the execute stage and dmem.
// Build option: define LSU_SPLIT_LOAD_EN to serve misaligned loads (two reads when crossing a word).
module lsu_mem_access #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [2:0]   req_funct3,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_rdata,
  output logic         resp_fault,
  output logic [N-1:0] DM_writeData,
  output logic [7:0]   wordAddr,
  output logic         readEnable,
  output logic         writeEnable,
  output logic [2:0]   memWidth,
  output logic [2:0]   byteOffset,
  input  logic [N-1:0] DM_readData
);

  // state | meaning
  // IDLE  | waiting for a request; memory controls follow the request
  // LOAD1 | first read word returns; second read issued if the load is split
  // LOAD2 | second read word returns
  // RESP  | response presented until resp_ready
  typedef enum logic [1:0] {IDLE, LOAD1, LOAD2, RESP} state_t;

  state_t      state, state_nxt;
  logic [10:0] addr_q;
  logic [2:0]  funct3_q;
  logic [3:0]  size, size_m1;
  logic        misaligned, fault;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[N-1:11];

  assign size       = 4'd1 << req_funct3[1:0];
  assign size_m1    = size - 4'd1;
  assign misaligned = |(req_addr[2:0] & size_m1[2:0]);

`ifdef LSU_SPLIT_LOAD_EN
  logic [N-1:0] low_q;
  logic [3:0]   size_q;
  logic         split_q;

  assign size_q  = 4'd1 << funct3_q[1:0];
  assign split_q = ({1'b0, addr_q[2:0]} + size_q) > 4'd8;
  assign fault   = (req_funct3 == 3'b111) | (req_write & req_funct3[2]) |
                   (req_write & misaligned);
`else
  assign fault   = (req_funct3 == 3'b111) | (req_write & req_funct3[2]) | misaligned;
`endif

  // Shift the {high,low} pair down to the accessed bytes, then extend to N bits.
  function automatic logic [N-1:0] load_result(input logic [2*N-1:0] pair,
                                               input logic [2:0] off,
                                               input logic [2:0] f3);
    logic [N-1:0] word;
    word = N'(pair >> {off, 3'b000});
    case (f3[1:0])
      2'd0:    load_result = f3[2] ? {{(N-8){1'b0}}, word[7:0]}
                                   : {{(N-8){word[7]}}, word[7:0]};
      2'd1:    load_result = f3[2] ? {{(N-16){1'b0}}, word[15:0]}
                                   : {{(N-16){word[15]}}, word[15:0]};
      2'd2:    load_result = f3[2] ? {{(N-32){1'b0}}, word[31:0]}
                                   : {{(N-32){word[31]}}, word[31:0]};
      default: load_result = word;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = (fault | req_write) ? RESP : LOAD1;
`ifdef LSU_SPLIT_LOAD_EN
      LOAD1:   state_nxt = split_q ? LOAD2 : RESP;
      LOAD2:   state_nxt = RESP;
`else
      LOAD1:   state_nxt = RESP;
`endif
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    readEnable   = 1'b0;
    writeEnable  = 1'b0;
    wordAddr     = addr_q[10:3];
    byteOffset   = addr_q[2:0];
    memWidth     = funct3_q;
    DM_writeData = '0;
    case (state)
      IDLE: begin
        wordAddr     = req_addr[10:3];
        byteOffset   = req_addr[2:0];
        memWidth     = req_funct3;
        DM_writeData = req_wdata << {req_addr[2:0], 3'b000};
        readEnable   = req_valid & ~req_write & ~fault;
        writeEnable  = req_valid & req_write & ~fault;
      end
`ifdef LSU_SPLIT_LOAD_EN
      LOAD1: if (split_q) begin
        readEnable = 1'b1;
        wordAddr   = addr_q[10:3] + 8'd1;
      end
`endif
      default: ;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      funct3_q   <= '0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
`ifdef LSU_SPLIT_LOAD_EN
      low_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q     <= req_addr[10:0];
          funct3_q   <= req_funct3;
          resp_fault <= fault;
          resp_rdata <= '0;
        end
`ifdef LSU_SPLIT_LOAD_EN
        LOAD1: begin
          low_q <= DM_readData;
          if (!split_q) resp_rdata <= load_result({{N{1'b0}}, DM_readData}, addr_q[2:0], funct3_q);
        end
        LOAD2: resp_rdata <= load_result({DM_readData, low_q}, addr_q[2:0], funct3_q);
`else
        LOAD1: resp_rdata <= load_result({{N{1'b0}}, DM_readData}, addr_q[2:0], funct3_q);
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Testbench for lsu_mem_access: table vectors, corner sequences and random traffic
// against a byte-array reference model; the bench also plays the dmem role.
module tb_lsu_mem_access;

`ifdef LSU_SPLIT_LOAD_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_fault, readEnable, writeEnable;
  logic [63:0] resp_rdata, DM_writeData, DM_readData;
  logic [7:0]  wordAddr;
  logic [2:0]  memWidth, byteOffset;

  int tests = 0;
  int fails = 0;

  logic [63:0] mem [256];
  logic [7:0]  ref_mem [2048];
  logic [7:0]  rd_log [$];

  always #5 clk = ~clk;

  lsu_mem_access #(.N(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .DM_writeData(DM_writeData), .wordAddr(wordAddr),
    .readEnable(readEnable), .writeEnable(writeEnable), .memWidth(memWidth),
    .byteOffset(byteOffset), .DM_readData(DM_readData)
  );

  // dmem: one-cycle read latency, byte-lane writes
  always @(posedge clk) begin
    if (readEnable) begin
      DM_readData <= mem[wordAddr];
      rd_log.push_back(wordAddr);
    end
    if (writeEnable)
      for (int i = 0; i < 8; i++)
        if (i >= int'(byteOffset) && i < int'(byteOffset) + (1 << memWidth[1:0]))
          mem[wordAddr][8*i +: 8] = DM_writeData[8*i +: 8];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: bytes addressed modulo 2 KiB, rules taken straight from the access definition.
  task automatic model(input logic w, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, output logic [63:0] rd,
                       output logic flt, output int lat);
    int size, a, off;
    logic [63:0] v;
    logic mis;
    size = 1 << f3[1:0];
    a    = int'(addr[10:0]);
    off  = a % 8;
    mis  = (a % size) != 0;
    flt  = (f3 == 3'b111) || (w && f3[2]) || (mis && (w || !SPLIT));
    rd   = '0;
    lat  = 1;
    if (!flt && w) begin
      for (int i = 0; i < size; i++) ref_mem[(a + i) % 2048] = wdata[8*i +: 8];
    end else if (!flt) begin
      v = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[(a + i) % 2048];
      if (!f3[2] && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8*size));
      rd  = v;
      lat = (off + size > 8) ? 3 : 2;
    end
  endtask

  task automatic run_req(input logic w, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input int stall,
                         output logic [63:0] ard, output logic aflt, output int alat);
    logic [63:0] erd, hold;
    logic        eflt;
    int          elat, off, nreads;
    logic [7:0]  wa_next;
    model(w, f3, addr, wdata, erd, eflt, elat);
    off     = int'(addr[2:0]);
    wa_next = addr[10:3] + 8'd1;
    @(negedge clk);
    rd_log.delete();
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    #1;
    chk("req_ready_T", req_ready, 1'b1);
    chk("readEnable_T", readEnable, !w && !eflt);
    chk("writeEnable_T", writeEnable, w && !eflt);
    chk("wordAddr_T", wordAddr, addr[10:3]);
    chk("byteOffset_T", byteOffset, addr[2:0]);
    chk("memWidth_T", memWidth, f3);
    if (w && !eflt) chk("DM_writeData_T", DM_writeData, wdata << (8*off));
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    alat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        alat = c;
        break;
      end
    end
    ard  = resp_rdata;
    aflt = resp_fault;
    if (alat == 0) begin
      tests++; fails++;
      $display("FAIL resp_timeout: got no resp_valid, expected one within 8 cycles");
      return;
    end
    chk("req_ready_busy", req_ready, 1'b0);
    hold = resp_rdata;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", resp_valid, 1'b1);
      chk("stall_rdata", resp_rdata, hold);
      chk("stall_fault", resp_fault, aflt);
      chk("stall_req_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("resp_valid_after", resp_valid, 1'b0);
    chk("rdata", ard, erd);
    chk("fault", aflt, eflt);
    chk("latency", alat, elat);
    nreads = (w || eflt) ? 0 : elat - 1;
    chk("read_count", rd_log.size(), nreads);
    if (nreads >= 1 && rd_log.size() >= 1) chk("read0_addr", rd_log[0], addr[10:3]);
    if (nreads == 2 && rd_log.size() >= 2) chk("read1_addr", rd_log[1], wa_next);
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
  } vec_t;

  vec_t vecs [$];

  initial begin
    logic [63:0] ard, a;
    logic        aflt, w;
    logic [2:0]  f3;
    int          alat;

    for (int i = 0; i < 256; i++) begin
      mem[i] = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) ref_mem[i*8 + b] = mem[i][8*b +: 8];
    end

    vecs.push_back('{1'b1, 3'd3, 64'h10, 64'h1122334455667788, 64'h0, 1'b0, 1});
    vecs.push_back('{1'b0, 3'd3, 64'h10, 64'h0, 64'h1122334455667788, 1'b0, 2});
    vecs.push_back('{1'b1, 3'd3, 64'h20, 64'h0807060504030201, 64'h0, 1'b0, 1});
    vecs.push_back('{1'b1, 3'd0, 64'h23, 64'hAB, 64'h0, 1'b0, 1});
    vecs.push_back('{1'b0, 3'd0, 64'h23, 64'h0, 64'hFFFFFFFFFFFFFFAB, 1'b0, 2});
    vecs.push_back('{1'b0, 3'd4, 64'h23, 64'h0, 64'hAB, 1'b0, 2});
    vecs.push_back('{1'b0, 3'd1, 64'h22, 64'h0, 64'hFFFFFFFFFFFFAB03, 1'b0, 2});
    vecs.push_back('{1'b0, 3'd5, 64'h24, 64'h0, 64'h0605, 1'b0, 2});
    vecs.push_back('{1'b0, 3'd6, 64'h24, 64'h0, 64'h08070605, 1'b0, 2});
`ifdef LSU_SPLIT_LOAD_EN
    vecs.push_back('{1'b0, 3'd2, 64'h22, 64'h0, 64'h000000000605AB03, 1'b0, 2});
`else
    vecs.push_back('{1'b0, 3'd2, 64'h22, 64'h0, 64'h0, 1'b1, 1});
`endif
    vecs.push_back('{1'b1, 3'd2, 64'h22, 64'h5555, 64'h0, 1'b1, 1});
    vecs.push_back('{1'b0, 3'd7, 64'h10, 64'h0, 64'h0, 1'b1, 1});
    vecs.push_back('{1'b1, 3'd4, 64'h30, 64'h77, 64'h0, 1'b1, 1});
    vecs.push_back('{1'b1, 3'd1, 64'h21, 64'h1234, 64'h0, 1'b1, 1});
    vecs.push_back('{1'b0, 3'd3, 64'hFFFF000000000010, 64'h0, 64'h1122334455667788, 1'b0, 2});

    // reset state
    #12;
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_fault", resp_fault, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 64'h0);
    chk("rst_readEnable", readEnable, 1'b0);
    chk("rst_writeEnable", writeEnable, 1'b0);
    chk("rst_DM_writeData", DM_writeData, 64'h0);
    chk("rst_wordAddr", wordAddr, 8'h0);
    chk("rst_byteOffset", byteOffset, 3'h0);
    chk("rst_memWidth", memWidth, 3'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("rst_req_ready", req_ready, 1'b1);

    foreach (vecs[i]) begin
      run_req(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 0, ard, aflt, alat);
      chk($sformatf("vec%0d_rdata", i), ard, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_fault", i), aflt, vecs[i].exp_fault);
      chk($sformatf("vec%0d_lat", i), alat, vecs[i].exp_lat);
    end

    // split load wrapping from word 255 to word 0 (faults when split loads are disabled)
    run_req(1'b0, 3'd3, 64'h7FD, 64'h0, 0, ard, aflt, alat);
    chk("split_lat", alat, SPLIT ? 3 : 1);
    chk("split_fault", aflt, !SPLIT);

    // backpressure for 3 cycles
    run_req(1'b0, 3'd3, 64'h10, 64'h0, 3, ard, aflt, alat);
    chk("bp_rdata", ard, 64'h1122334455667788);

    // reset while in LOAD1
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd3; req_addr = 64'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_resp_valid", resp_valid, 1'b0);
    chk("midrst_readEnable", readEnable, 1'b0);
    chk("midrst_resp_rdata", resp_rdata, 64'h0);
    chk("midrst_resp_fault", resp_fault, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("midrst_req_ready", req_ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_no_resp", resp_valid, 1'b0);
    end

    // random traffic against the reference model
    for (int n = 0; n < 80; n++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a[2:0] = a[2:0] & ~(3'((1 << f3[1:0]) - 1));
      run_req(w, f3, a, {$urandom, $urandom}, int'($urandom_range(0, 2)), ard, aflt, alat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_mem_access.md
# lsu_mem_access

Load/store access unit between the execute stage and the `dmem` data memory. It accepts one memory request at a time over a valid/ready handshake and converts the byte address into word address, byte offset and width. Store data is shifted into the correct byte lanes before it reaches memory. Load data returning from `dmem` (one-cycle read latency) is aligned and sign- or zero-extended, then returned on a valid/ready response channel.

## Interface
- `N`, 64: data and address width.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the unit accepts a request; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV64 width code.
  - 000 B, 001 H, 010 W, 011 D.
  - 100 BU, 101 HU, 110 WU.
- `req_addr` in N: byte address. Only bits [10:0] are used.
- `req_wdata` in N: store data, right-justified.
- `resp_valid` out 1: a response is available.
- `resp_ready` in 1: the consumer takes the response.
- `resp_rdata` out N: extended load data. It is 0 for stores and faults.
- `resp_fault` out 1: the access was rejected. No memory side effect occurred.
- `DM_writeData` out N: store data shifted left by `byteOffset*8`.
- `wordAddr` out 8: word address, `addr[10:3]`.
- `readEnable` out 1: memory read enable.
- `writeEnable` out 1: memory write enable.
- `memWidth` out 3: equals `req_funct3`.
- `byteOffset` out 3: byte offset, `addr[2:0]`.
- `DM_readData` in N: memory read data. It is valid the cycle after `readEnable` is asserted.

## Operation
- States: IDLE, LOAD1, LOAD2, RESP.
- Fault conditions:
  - `funct3` = 111.
  - A store with `funct3[2]` = 1.
  - A misaligned access, meaning `addr` is not a multiple of the size. The exception under `LSU_SPLIT_LOAD_EN` is described in Configuration.
- Memory control outputs are combinational from the request in IDLE.
  - `readEnable = req_valid & ~req_write & ~fault` in IDLE.
  - `writeEnable = req_valid & req_write & ~fault` in IDLE.
  - A faulting request never asserts an enable.
- Transitions out of IDLE on accept:
  - Store or fault: go to RESP.
  - Load: go to LOAD1.
- LOAD1:
  - Capture `DM_readData` into the low word register.
  - If the access crosses a word boundary (split load): assert `readEnable` with `wordAddr = addr[10:3]+1` (8-bit wrap, so 255→0), then go to LOAD2.
  - Otherwise go to RESP.
- LOAD2: capture `DM_readData` into the high word register, then go to RESP.
- Load result formation:
  - Take `{high,low} >> (offset*8)` and truncate to the access size.
  - Sign-extend for B/H/W; zero-extend for BU/HU/WU.
  - The result is registered into `resp_rdata`.
- RESP:
  - `resp_valid` = 1.
  - `resp_rdata` and `resp_fault` are held stable until `resp_ready`.
  - On `resp_ready`, go to IDLE.
- Reset, including mid-operation:
  - State returns to IDLE.
  - `resp_valid`, `resp_fault`, `resp_rdata`, `readEnable` and `writeEnable` all go to 0.
  - Any pending response is dropped. A write already issued stays in memory.
- Address bits above [10] are ignored; they produce no range fault.

## Timing
- All timings are relative to the accept cycle T (`req_valid & req_ready`).
- Store: `writeEnable` asserted in T; `resp_valid` in T+1.
- Fault: no enable asserted; `resp_valid` with `resp_fault` = 1 in T+1.
- Load: `readEnable` asserted in T; `resp_valid` in T+2.
- Split load: reads issued in T and T+1; `resp_valid` in T+3.
- Throughput is one request per 2 cycles minimum, because `req_ready` = 0 outside IDLE.
- Backpressure: `resp_ready` held low extends RESP indefinitely, with no output change.

## Configuration
- `LSU_SPLIT_LOAD_EN` defined:
  - Misaligned loads are permitted.
  - If `offset + size <= 8`, the load is served by a single read.
  - Otherwise it is a split load through LOAD2.
  - Misaligned stores still fault.
- `LSU_SPLIT_LOAD_EN` undefined:
  - Every misaligned load or store faults.
  - LOAD2 is not compiled in.

## Test plan
- Reset state: assert `reset_n` = 0. Required: all outputs 0 and `req_ready` = 1 once `reset_n` = 1.
- Doubleword round-trip:
  - Stimulus: SD `0x1122334455667788` to address `0x10`, then LD `0x10`.
  - Required: `wordAddr` = 2, `byteOffset` = 0, `writeEnable` high in T.
  - Required: the load returns `0x1122334455667788` with `resp_valid` in T+2.
- Byte store and extension:
  - Stimulus: SB `0xAB` to address `0x23`.
  - Required: `DM_writeData` = `0xAB000000`.
  - Required: LB `0x23` returns `0xFFFFFFFFFFFFFFAB`; LBU `0x23` returns `0xAB`.
- Misaligned word load: LW at `0x22`.
  - Without the macro: `resp_fault` = 1 in T+1 and `readEnable` never asserted.
  - With the macro: correct data in T+2.
- Split load with wrap (macro on): LD at `0x7FD`.
  - Required: reads of word 255 then word 0.
  - Required: result is bytes 5..7 of word 255 plus bytes 0..4 of word 0, delivered in T+3.
- Backpressure and reset mid-operation:
  - Stimulus: `resp_ready` = 0 for 3 cycles.
  - Required: response stable and `req_ready` = 0.
  - Stimulus: assert `reset_n` in LOAD1.
  - Required: IDLE with no `resp_valid`.
